// File: rtl/io_bus_arbiter.sv
// io_bus_arbiter
//
// Round-robin owner selection and turnaround sequencing for one shared
// bidirectional net. At most one requester may drive the net at a time. A
// gap of TURNAROUND all-released cycles separates any two owners, and a
// long tenure is revoked when another requester is waiting.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   req        per-requester level request
//   grant      registered one-hot (or zero) ownership
//   oe         registered drive enables, same value as grant
//   owner      index of the current owner; keeps the last owner while idle
//   bus_idle   registered, high when no oe bit is set
//   timeout    one-cycle pulse on the cycle after a preempted owner's last
//   state_dbg  current FSM state (0 IDLE, 1 OWN, 2 TURN)
//
// Request/grant handshake: a requester holds req high for as long as it
// wants the net. grant[i] high means requester i may drive in that cycle.
// Dropping req[i] while granted hands the net back at the next edge.
// Requests that change during a turnaround are looked at only in the last
// turnaround cycle.
module io_bus_arbiter #(
  parameter int NREQ       = 4,
  parameter int MAX_HOLD   = 16,
  parameter int TURNAROUND = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req,
  output logic [NREQ-1:0]         grant,
  output logic [NREQ-1:0]         oe,
  output logic [$clog2(NREQ)-1:0] owner,
  output logic                    bus_idle,
  output logic                    timeout,
  output logic [1:0]              state_dbg
);

  localparam int PW = $clog2(NREQ);
  // With preemption disabled the hold counter is never consulted. A cap
  // of 1 keeps it at a legal, non-zero width.
  localparam int HOLD_SAT = (MAX_HOLD == 0) ? 1 : MAX_HOLD;
  localparam int HW       = $clog2(HOLD_SAT + 1);

  localparam logic [NREQ-1:0] ONE       = NREQ'(1);
  localparam logic [HW-1:0]   HOLD_CAP  = HW'(HOLD_SAT);
  localparam logic [3:0]      TURN_LAST = 4'(TURNAROUND);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_OWN  = 2'd1,
    S_TURN = 2'd2
  } state_t;

  state_t          state;
  logic [PW-1:0]   ptr;
  logic [HW-1:0]   hold_cnt;
  logic [3:0]      turn_cnt;
  // Set on the edge that sees a contested tenure at its cap. The revoke
  // happens one edge later, which gives a tenure of MAX_HOLD+1 cycles.
  logic            preempt_pend;

  logic            found;
  logic [PW-1:0]   winner;
  logic [PW-1:0]   scan_idx;
  logic [PW-1:0]   winner_next_ptr;
  logic [NREQ-1:0] winner_onehot;
  logic [NREQ-1:0] owner_mask;
  logic            others_req;
  logic            preempt_hit;

  assign state_dbg = state;

  // Round-robin search: the first set request at or after ptr wins.
  always_comb begin
    found    = 1'b0;
    winner   = '0;
    scan_idx = '0;
    for (int i = 0; i < NREQ; i++) begin
      scan_idx = PW'((int'(ptr) + i) % NREQ);
      if (!found && req[scan_idx]) begin
        found  = 1'b1;
        winner = scan_idx;
      end
    end
  end

  assign winner_next_ptr = (winner == PW'(NREQ - 1)) ? '0 : winner + 1'b1;
  assign winner_onehot   = ONE << winner;
  assign owner_mask      = ONE << owner;
  assign others_req      = |(req & ~owner_mask);
  assign preempt_hit     = (MAX_HOLD != 0) && (hold_cnt == HOLD_CAP) && others_req;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      grant        <= '0;
      oe           <= '0;
      owner        <= '0;
      bus_idle     <= 1'b1;
      timeout      <= 1'b0;
      ptr          <= '0;
      hold_cnt     <= '0;
      turn_cnt     <= '0;
      preempt_pend <= 1'b0;
    end else begin
      timeout <= 1'b0;
      case (state)
        S_IDLE, S_TURN: begin
          if (state == S_TURN && turn_cnt != TURN_LAST) begin
            turn_cnt <= turn_cnt + 4'd1;
          end else if (found) begin
            state        <= S_OWN;
            grant        <= winner_onehot;
            oe           <= winner_onehot;
            bus_idle     <= 1'b0;
            owner        <= winner;
            ptr          <= winner_next_ptr;
            hold_cnt     <= HW'(1);
            preempt_pend <= 1'b0;
            turn_cnt     <= '0;
          end else begin
            state    <= S_IDLE;
            turn_cnt <= '0;
          end
        end
        S_OWN: begin
          if (!req[owner] || preempt_pend) begin
            // A voluntary release wins over a pending preemption, and it
            // does not pulse timeout.
            state        <= S_TURN;
            grant        <= '0;
            oe           <= '0;
            bus_idle     <= 1'b1;
            timeout      <= req[owner];
            hold_cnt     <= '0;
            turn_cnt     <= 4'd1;
            preempt_pend <= 1'b0;
          end else begin
            if (preempt_hit) preempt_pend <= 1'b1;
            if (hold_cnt != HOLD_CAP) hold_cnt <= hold_cnt + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_io_bus_arbiter.sv
// Testbench for io_bus_arbiter. The main instance uses four requesters,
// MAX_HOLD=4 and TURNAROUND=2. A second instance with preemption disabled
// covers the lone-owner case.
module tb_io_bus_arbiter;

  localparam int N  = 4;
  localparam int MH = 4;
  localparam int TA = 2;

  // ---------------- clock / reset / DUT ----------------
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] req = '0;
  logic [3:0] req2 = '0;

  logic [3:0] grant, oe, grant2, oe2;
  logic [1:0] owner, owner2, state_dbg, state_dbg2;
  logic       bus_idle, timeout, bus_idle2, timeout2;

  always #5 clk = ~clk;

  io_bus_arbiter #(.NREQ(N), .MAX_HOLD(MH), .TURNAROUND(TA)) dut (
    .clk(clk), .rst(rst), .req(req), .grant(grant), .oe(oe), .owner(owner),
    .bus_idle(bus_idle), .timeout(timeout), .state_dbg(state_dbg)
  );

  io_bus_arbiter #(.NREQ(N), .MAX_HOLD(0), .TURNAROUND(1)) dut_nohold (
    .clk(clk), .rst(rst), .req(req2), .grant(grant2), .oe(oe2), .owner(owner2),
    .bus_idle(bus_idle2), .timeout(timeout2), .state_dbg(state_dbg2)
  );

  // ---------------- bookkeeping ----------------
  int n_checks = 0;
  int n_errors = 0;

  // Expected outputs after each edge: {grant, owner, bus_idle, timeout}.
  logic [7:0] exp_q[$];

  // Tenure log built from DUT outputs, used by the directed checks.
  int own_log[$];
  int len_log[$];
  int gap_log[$];
  int to_cnt   = 0;
  int cur_len  = 0;
  int idle_run = 0;

  task automatic check(input string name, input int act, input int expv);
    n_checks++;
    if (act != expv) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
    end
  endtask

  task automatic clear_logs();
    own_log.delete();
    len_log.delete();
    gap_log.delete();
    to_cnt   = 0;
    idle_run = 0;
  endtask

  // ---------------- reference model ----------------
  // Describes the bus as "who owns it and for how long", plus the
  // remaining gap cycles. It is stepped once per edge.
  bit m_busy  = 1'b0;
  int m_owner = 0;
  int m_ptr   = 0;
  int m_ten   = 0;    // cycles of the current tenure, including this one
  bit m_armed = 1'b0; // contested at the cap: revoke on the next edge
  int m_gap   = 0;    // turnaround cycles still to run, 0 when idle
  bit m_to    = 1'b0;

  function automatic int pick(input logic [3:0] r);
    for (int k = 0; k < N; k++) begin
      int c;
      c = (m_ptr + k) % N;
      if (r[c]) return c;
    end
    return -1;
  endfunction

  task automatic model_step();
    int w;
    logic [3:0] g;
    m_to = 1'b0;
    if (rst) begin
      m_busy = 1'b0; m_owner = 0; m_ptr = 0; m_ten = 0; m_armed = 1'b0; m_gap = 0;
    end else if (m_busy) begin
      if (!req[m_owner]) begin
        m_busy = 1'b0; m_gap = TA; m_armed = 1'b0;
      end else if (m_armed) begin
        m_busy = 1'b0; m_gap = TA; m_armed = 1'b0; m_to = 1'b1;
      end else begin
        if (m_ten >= MH && (req & ~(4'b0001 << m_owner)) != 4'b0000) m_armed = 1'b1;
        m_ten++;
      end
    end else if (m_gap > 1) begin
      m_gap--;
    end else begin
      m_gap = 0;
      w = pick(req);
      if (w >= 0) begin
        m_busy = 1'b1; m_owner = w; m_ptr = (w + 1) % N; m_ten = 1; m_armed = 1'b0;
      end
    end
    g = m_busy ? (4'b0001 << m_owner) : 4'b0000;
    exp_q.push_back({g, 2'(m_owner), ~m_busy, m_to});
  endtask

  // ---------------- driver ----------------
  task automatic drive(input logic r, input logic [3:0] q);
    @(negedge clk);
    rst = r;
    req = q;
    model_step();
  endtask

  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  // ---------------- monitor / scoreboard ----------------
  initial begin
    logic [7:0] e;
    logic [3:0] prev_g;
    int idx;
    prev_g = '0;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() == 0) begin
        check("queue_underflow", 0, 1);
      end else begin
        e = exp_q.pop_front();
        check("grant", int'(grant), int'(e[7:4]));
        check("oe", int'(oe), int'(e[7:4]));
        check("owner", int'(owner), int'(e[3:2]));
        check("bus_idle", int'(bus_idle), int'(e[1]));
        check("timeout", int'(timeout), int'(e[0]));
      end
      check("onehot", int'($countones(oe) <= 1), 1);
      idx = 0;
      for (int k = 0; k < N; k++) if (grant[k]) idx = k;
      if (grant != 0 && prev_g == 0) begin
        own_log.push_back(idx);
        gap_log.push_back(idle_run);
        cur_len = 1;
      end else if (grant != 0) begin
        cur_len++;
      end else if (prev_g != 0) begin
        len_log.push_back(cur_len);
        idle_run = 1;
      end else begin
        idle_run++;
      end
      if (timeout) to_cnt++;
      prev_g = grant;
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [3:0] q;
    bit r3;
    int held3;

    // Expected values for the first edge, reset asserted.
    model_step();

    // Reset, then a single request on bit 2.
    drive(1, 4'b0000);
    drive(0, 4'b0000);
    drive(0, 4'b0000);
    clear_logs();
    for (int i = 0; i < 4; i++) drive(0, 4'b0100);
    settle();
    check("single_owner", own_log.size() > 0 ? own_log[0] : -1, 2);
    check("single_no_timeout", to_cnt, 0);
    for (int i = 0; i < 4; i++) drive(0, 4'b0000);

    // Release followed by turnaround: owner 0 drops after 2 cycles.
    drive(1, 4'b0000);
    clear_logs();
    for (int i = 0; i < 20; i++) begin
      if (m_busy && m_owner == 0 && m_ten == 2) break;
      drive(0, 4'b0011);
    end
    for (int i = 0; i < 7; i++) drive(0, 4'b0010);
    for (int i = 0; i < 4; i++) drive(0, 4'b0000);
    settle();
    check("rel_first_owner", own_log.size() > 0 ? own_log[0] : -1, 0);
    check("rel_first_len", len_log.size() > 0 ? len_log[0] : -1, 2);
    check("rel_second_owner", own_log.size() > 1 ? own_log[1] : -1, 1);
    check("rel_gap", gap_log.size() > 1 ? gap_log[1] : -1, TA);

    // Round robin: all requesting, each owner lets go after 3 cycles.
    drive(1, 4'b0000);
    clear_logs();
    for (int i = 0; i < 40; i++) begin
      q = 4'b1111;
      if (m_busy && m_ten == 3) q[m_owner] = 1'b0;
      drive(0, q);
    end
    for (int i = 0; i < 4; i++) drive(0, 4'b0000);
    settle();
    for (int k = 0; k < 5; k++)
      check($sformatf("rr_owner%0d", k), own_log.size() > k ? own_log[k] : -1, k % N);
    for (int k = 0; k < 4; k++)
      check($sformatf("rr_len%0d", k), len_log.size() > k ? len_log[k] : -1, 3);
    for (int k = 1; k < 5; k++)
      check($sformatf("rr_gap%0d", k), gap_log.size() > k ? gap_log[k] : -1, TA);
    check("rr_no_timeout", to_cnt, 0);

    // Preemption: req[1] owns, req[3] rises in tenure cycle 2.
    drive(1, 4'b0000);
    clear_logs();
    r3 = 1'b0;
    held3 = 0;
    for (int i = 0; i < 40; i++) begin
      if (m_busy && m_owner == 1 && m_ten >= 2) r3 = 1'b1;
      if (m_busy && m_owner == 3) held3++;
      if (held3 >= 3) break;
      q = (m_busy && m_owner == 3) ? 4'b1000 : {r3, 1'b0, 1'b1, 1'b0};
      drive(0, q);
    end
    for (int i = 0; i < 4; i++) drive(0, 4'b0000);
    settle();
    check("pre_owner1", own_log.size() > 0 ? own_log[0] : -1, 1);
    check("pre_len", len_log.size() > 0 ? len_log[0] : -1, MH + 1);
    check("pre_owner3", own_log.size() > 1 ? own_log[1] : -1, 3);
    check("pre_gap", gap_log.size() > 1 ? gap_log[1] : -1, TA);
    check("pre_timeouts", to_cnt, 1);

    // Reset in the middle of a tenure: no turnaround owed afterwards.
    drive(1, 4'b0000);
    for (int i = 0; i < 6; i++) drive(0, 4'b1000);
    clear_logs();
    drive(1, 4'b1000);
    for (int i = 0; i < 3; i++) drive(0, 4'b1000);
    settle();
    check("rst_regrant_owner", own_log.size() > 0 ? own_log[0] : -1, 3);
    check("rst_regrant_gap", gap_log.size() > 0 ? gap_log[0] : -1, 1);
    for (int i = 0; i < 3; i++) drive(0, 4'b0000);

    // Lone owner with preemption disabled, then a second requester.
    drive(1, 4'b0000);
    for (int i = 0; i < 130; i++) begin
      drive(0, 4'b0000);
      if (i >= 1) begin
        check("lone_grant", int'(grant2), 4'b0001);
        check("lone_timeout", int'(timeout2), 0);
      end
      req2 = (i < 100) ? 4'b0001 : 4'b0101;
    end
    req2 = 4'b0000;

    // Random traffic with occasional resets.
    drive(1, 4'b0000);
    q = 4'b0000;
    for (int i = 0; i < 1500; i++) begin
      for (int k = 0; k < N; k++)
        if ($urandom_range(0, 4) == 0) q[k] = ~q[k];
      drive(($urandom_range(0, 199) == 0) ? 1'b1 : 1'b0, q);
    end
    for (int i = 0; i < 3; i++) drive(0, 4'b0000);
    settle();
    check("queue_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/io_bus_arbiter.md
# io_bus_arbiter

Round-robin arbiter and turnaround sequencer for a single shared bidirectional (inout) net driven by up to NREQ cell instances. It grants exactly one requester the right to drive the net, inserts a mandatory all-released turnaround gap between owners so two drivers never overlap, and revokes long tenures when others are waiting. It sits beside the instances whose `io` pins share one net, and drives their output-enables.

## Interface
- NREQ, 4: number of requesters; range 2..16.
- MAX_HOLD, 16: maximum consecutive grant cycles while another requester waits; 0 disables preemption.
- TURNAROUND, 1: idle cycles with no output-enable between owners; range 1..15.

- clk  input  1  rising-edge clock; the only clock.
- rst  input  1  synchronous, active-high reset.
- req  input  NREQ  per-requester level request; held high while the requester wants the net.
- grant  output  NREQ  one-hot (or zero) ownership; registered.
- oe  output  NREQ  per-requester drive enable; equals grant, registered separately.
- owner  output  clog2(NREQ)  index of current owner; holds the last owner when no grant is active.
- bus_idle  output  1  high when no oe bit is set.
- timeout  output  1  one-cycle pulse when an owner is preempted.

## Operation
- States: IDLE, OWN, TURN.
- IDLE: all grant/oe low. If any req bit is high, pick a winner by round-robin starting at pointer ptr, then go to OWN with grant[winner]=1.
- Round-robin: the search order is ptr, ptr+1, … modulo NREQ. The first set req bit wins. On every grant, ptr becomes winner+1 modulo NREQ.
- OWN: hold_cnt increments each cycle and saturates at MAX_HOLD. It is 1 in the first grant cycle.
- Leaving OWN:
  - If req[owner] is low, release the net and go to TURN.
  - Otherwise, if MAX_HOLD≠0, hold_cnt==MAX_HOLD, and any other req bit is high, revoke the grant, pulse timeout and go to TURN.
  - Otherwise, stay in OWN.
- Release has priority over preemption in the same cycle; timeout is not pulsed on release.
- Owner alone at MAX_HOLD: no preemption. hold_cnt stays saturated and preemption occurs the cycle after another req rises.
- TURN: all grant/oe low for exactly TURNAROUND cycles, counted by turn_cnt.
  - In the last TURN cycle, arbitrate as in IDLE: go to OWN if any req is high, otherwise go to IDLE.
- A preempted owner that keeps req high re-enters arbitration normally. Its ptr has advanced past it, so it is served last.
- The grant and oe vectors are never multi-hot. Any non-zero oe is always preceded by at least TURNAROUND cycles of all-zero oe after a previous owner.
- req bits changing during TURN are sampled only in the final TURN cycle.
- Reset values: grant=0, oe=0, owner=0, bus_idle=1, timeout=0, ptr=0, hold_cnt=0, turn_cnt=0, state IDLE. A reset during OWN or TURN drops all enables the next edge and no turnaround is owed afterwards.

## Timing
- Arbitration latency: req sampled high in IDLE at edge t gives grant/oe high after edge t+1. This is one cycle of latency.
- Release: req[owner] low at edge t gives grant low after edge t+1. The next grant appears after edge t+1+TURNAROUND at the earliest.
- Preemption: the condition is seen at edge t; grant drops and timeout=1 after edge t+1, with timeout low again after edge t+2.
- Maximum uninterrupted tenure with contention: MAX_HOLD+1 cycles of oe high (detection plus revoke edge).
- owner updates on the same edge that grant rises; bus_idle is registered together with oe.
- Widths: hold_cnt is clog2(MAX_HOLD+1) bits, turn_cnt is 4 bits, ptr is clog2(NREQ) bits. All comparisons are unsigned and the wrap is modulo NREQ.

## Test plan
- Reset then single request:
  - Stimulus: rst 2 cycles; req=0b0100 from cycle 5.
  - Response: grant=0b0100 and owner=2 from cycle 6; bus_idle=0; timeout never.
- Release and turnaround (TURNAROUND=2):
  - Stimulus: owner 0; req=0b0011; req[0] drops at cycle 10.
  - Response: grant=0 in cycles 11–12; grant=0b0010 at cycle 13.
- Round-robin fairness:
  - Stimulus: all four req held high, each owner releases after 3 cycles.
  - Response: owners 0,1,2,3,0 in order; no overlapping oe.
- Preemption (MAX_HOLD=4):
  - Stimulus: req[1] held high and granted; req[3] rises at cycle 2 of the tenure.
  - Response: grant[1] high for exactly 5 cycles; timeout one pulse as it drops; grant[3] after TURNAROUND.
- Lone owner with preemption disabled (MAX_HOLD=0):
  - Stimulus: req[0] held high for 100 cycles, then req[2] rises.
  - Response: no preemption; timeout never; grant[0] stays high.
- Reset mid-tenure:
  - Stimulus: assert rst while grant=0b1000.
  - Response: grant=0, oe=0, bus_idle=1, owner=0 next cycle; with req=0b1000 after rst low, grant returns one cycle later.
